piso_stream: RTL and testbench
==============================

PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..32.
REQ-002 Parameter LSB_FIRST, default 1; 1 = bit 0 shifted out first, 0 = bit WIDTH-1 first.
REQ-003 Parameter IDLE_LEVEL, default 1'b0, value driven on so while no frame is active.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset, sampled on rising clk.
REQ-006 pi  input  WIDTH  parallel word to serialise.
REQ-007 load_valid  input  1  pi is valid and offered for loading.
REQ-008 load_ready  output  1  block accepts pi this cycle; load occurs when load_valid & load_ready at a rising edge.
REQ-009 shift_en  input  1  advance enable; 0 stalls the frame with so held.
REQ-010 so  output  1  serial data out, registered.
REQ-011 so_valid  output  1  so carries a frame bit this cycle.
REQ-012 so_last  output  1  so carries the final bit of the frame.
REQ-013 busy  output  1  high while state is SHIFT.

Function
REQ-014 Two states SHALL exist: IDLE and SHIFT, plus a bit counter sized to count 0..FRAME-1, where FRAME = WIDTH (WIDTH+1 with parity, see REQ-029).
REQ-015 In IDLE, load_ready SHALL be 1, so = IDLE_LEVEL, so_valid = 0, so_last = 0.
REQ-016 An accepted load in IDLE SHALL capture pi, enter SHIFT, and present the first frame bit on so with so_valid = 1 in the cycle after the accepting edge (latency 1 cycle).
REQ-017 In SHIFT, each rising edge with shift_en = 1 SHALL advance so to the next bit in LSB_FIRST order; with shift_en = 0 so, so_valid, so_last and the counter SHALL hold.
REQ-018 so_last SHALL be 1 exactly while the final frame bit is on so and so_valid = 1.
REQ-019 In SHIFT, load_ready SHALL be 1 only when so_last = 1 and shift_en = 1 (combinational); otherwise 0.
REQ-020 An accepted load coincident with the final-bit advance SHALL start the next frame with no idle cycle: first bit of the new word on so in the next cycle.
REQ-021 Final-bit advance without a load SHALL return to IDLE and drive IDLE_LEVEL on so next cycle.
REQ-022 pi and load_valid SHALL be ignored whenever load_ready = 0; the frame in progress SHALL be unaffected.
REQ-023 Shifted-in fill bits SHALL be 0 internally; they SHALL never appear on so while so_valid = 1.
REQ-024 busy SHALL equal (state == SHIFT).

Reset
REQ-025 rst = 1 at a rising edge SHALL force IDLE, counter 0, shift register 0, so = IDLE_LEVEL, so_valid = 0, so_last = 0, busy = 0, regardless of load_valid or shift_en.
REQ-026 rst SHALL have priority over load and shift; a frame in progress SHALL be aborted with no further valid bits.
REQ-027 load_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro PISO_STREAM_PARITY_EN SHALL select an appended parity bit.
REQ-029 With PISO_STREAM_PARITY_EN defined: FRAME = WIDTH+1; after the WIDTH data bits, so SHALL carry even parity (XOR of all captured bits), and so_last SHALL mark the parity bit.
REQ-030 Without PISO_STREAM_PARITY_EN: FRAME = WIDTH; so_last marks the final data bit; no parity logic present.

Verification
REQ-031 WIDTH=4, LSB_FIRST=1, shift_en=1, load 4'b1010 once -> so = 0,1,0,1 on cycles 1..4 after load, so_last on cycle 4, so = IDLE_LEVEL and busy = 0 on cycle 5.
REQ-032 WIDTH=4, LSB_FIRST=0, back-to-back loads 4'b1100 then 4'b0011 held valid -> so = 1,1,0,0,0,0,1,1 with no gap, load_ready high only in cycles 0 and 4.
REQ-033 WIDTH=8, load 8'hA5, shift_en low for 3 cycles after bit 2 -> bit 2 held 3 extra cycles, remaining bits unchanged, total frame 11 valid cycles.
REQ-034 WIDTH=8, load 8'hFF, assert rst during bit 4 -> next cycle so_valid = 0, so = IDLE_LEVEL, load_ready = 1; following load 8'h01 serialises correctly.
REQ-035 PISO_STREAM_PARITY_EN defined, WIDTH=4, LSB_FIRST=1, load 4'b0111 -> so = 1,1,1,0,1, so_last on the fifth bit.
REQ-036 load_valid high with pi changing each cycle during a frame -> only the word present at the accepting edge is serialised.

Source files
------------

// File: rtl/piso_stream.sv
// Parallel-in / serial-out streamer with valid/ready load handshake and stall support.
// Optional even-parity bit appended after the data when PISO_STREAM_PARITY_EN is defined.
module piso_stream #(
    parameter int   WIDTH      = 8,
    parameter bit   LSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pi,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             so_last,
    output logic             busy
);

`ifdef PISO_STREAM_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW = $clog2(FRAME);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             so_q, so_d;
`ifdef PISO_STREAM_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             in_shift;
    logic             is_last;
    logic             advance;
    logic             load_go;
    logic             pi_first;
    logic [WIDTH-1:0] pi_rest;
    logic             sr_next_bit;
    logic [WIDTH-1:0] sr_shifted;

    assign in_shift   = (state_q == S_SHIFT);
    assign is_last    = in_shift && (cnt_q == LAST_IDX);
    assign advance    = in_shift && shift_en;
    assign load_ready = (state_q == S_IDLE) || (is_last && shift_en);
    assign load_go    = load_valid && load_ready;

    // The first bit goes straight to so_q; the shift register only keeps the remaining bits.
    assign pi_first    = LSB_FIRST ? pi[0] : pi[WIDTH-1];
    assign pi_rest     = LSB_FIRST ? (pi >> 1) : (pi << 1);
    assign sr_next_bit = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
    assign sr_shifted  = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        so_d    = so_q;
`ifdef PISO_STREAM_PARITY_EN
        par_d   = par_q;
`endif
        if (load_go) begin
            state_d = S_SHIFT;
            cnt_d   = '0;
            sr_d    = pi_rest;
            so_d    = pi_first;
`ifdef PISO_STREAM_PARITY_EN
            par_d   = ^pi;
`endif
        end else if (advance) begin
            if (is_last) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                sr_d    = '0;
                so_d    = IDLE_LEVEL;
            end else begin
                cnt_d = cnt_q + CW'(1);
`ifdef PISO_STREAM_PARITY_EN
                if (cnt_q == CW'(WIDTH - 1)) begin
                    so_d = par_q;
                end else begin
                    so_d = sr_next_bit;
                    sr_d = sr_shifted;
                end
`else
                so_d = sr_next_bit;
                sr_d = sr_shifted;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            so_q    <= IDLE_LEVEL;
`ifdef PISO_STREAM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            so_q    <= so_d;
`ifdef PISO_STREAM_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign so       = so_q;
    assign so_valid = in_shift;
    assign so_last  = is_last;
    assign busy     = in_shift;

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: three configurations checked every cycle against a frame-list model,
// plus fixed vector tables and hand sequences for stall, abort and back-to-back cases.
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct {
        logic       rst;
        logic       lv;
        logic [3:0] pi;
        logic       se;
        logic       so;
        logic       v;
        logic       l;
        logic       r;
        logic       b;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  rst_w, lv_w, se_w;
    logic [2:0]  so_w, sv_w, sl_w, lr_w, bz_w;
    logic [31:0] pi_w [3];

    int nchk = 0;
    int nerr = 0;

    // Model: the frame currently on the wire as a bit list in transmit order.
    logic [32:0] mfr  [3];
    int          mlen [3];
    int          mpos [3];

    piso_stream #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst_w[0]), .pi(pi_w[0][3:0]), .load_valid(lv_w[0]), .load_ready(lr_w[0]),
        .shift_en(se_w[0]), .so(so_w[0]), .so_valid(sv_w[0]), .so_last(sl_w[0]), .busy(bz_w[0]));
    piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_b (
        .clk(clk), .rst(rst_w[1]), .pi(pi_w[1][7:0]), .load_valid(lv_w[1]), .load_ready(lr_w[1]),
        .shift_en(se_w[1]), .so(so_w[1]), .so_valid(sv_w[1]), .so_last(sl_w[1]), .busy(bz_w[1]));
    piso_stream #(.WIDTH(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_c (
        .clk(clk), .rst(rst_w[2]), .pi(pi_w[2][3:0]), .load_valid(lv_w[2]), .load_ready(lr_w[2]),
        .shift_en(se_w[2]), .so(so_w[2]), .so_valid(sv_w[2]), .so_last(sl_w[2]), .busy(bz_w[2]));

    function automatic int wof(input int k);
        return (k == 1) ? 8 : 4;
    endfunction

    function automatic bit lsbof(input int k);
        return (k == 0);
    endfunction

    function automatic logic idleof(input int k);
        return (k == 2) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [32:0] frame_of(input int k, input logic [31:0] p);
        logic [32:0] f;
        logic        par;
        int          w;
        f   = '0;
        par = 1'b0;
        w   = wof(k);
        for (int i = 0; i < w; i++) begin
            f[i] = lsbof(k) ? p[i] : p[w-1-i];
            par  = par ^ p[i];
        end
        if (PAR == 1) f[w] = par;
        return f;
    endfunction

    function automatic vec_t mk(input logic rst, input logic lv, input logic [3:0] pi, input logic se,
                                input logic so, input logic v, input logic l, input logic r, input logic b);
        vec_t t;
        t.rst = rst; t.lv = lv; t.pi = pi; t.se = se;
        t.so = so; t.v = v; t.l = l; t.r = r; t.b = b;
        return t;
    endfunction

    task automatic chk(input string nm, input int k, input logic act, input logic exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d] t=%0t: got %b, want %b", nm, k, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s t=%0t: got %0d, want %0d", nm, $time, act, exp);
        end
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input bit use_t, input int tk, input vec_t r);
        bit   acc [3];
        bit   adv [3];
        logic e_b, e_so, e_l, e_r;
        @(negedge clk);
        if (use_t) begin
            chk("tbl_so",    tk, so_w[tk], r.so);
            chk("tbl_valid", tk, sv_w[tk], r.v);
            chk("tbl_last",  tk, sl_w[tk], r.l);
            chk("tbl_ready", tk, lr_w[tk], r.r);
            chk("tbl_busy",  tk, bz_w[tk], r.b);
        end
        for (int k = 0; k < 3; k++) begin
            e_b  = (mpos[k] < mlen[k]);
            e_so = e_b ? mfr[k][mpos[k]] : idleof(k);
            e_l  = e_b && (mpos[k] == mlen[k] - 1);
            e_r  = !e_b || (e_l && se_w[k]);
            chk("so",       k, so_w[k], e_so);
            chk("so_valid", k, sv_w[k], e_b);
            chk("so_last",  k, sl_w[k], e_l);
            chk("ready",    k, lr_w[k], e_r);
            chk("busy",     k, bz_w[k], e_b);
            acc[k] = lv_w[k] && e_r;
            adv[k] = e_b && se_w[k];
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (rst_w[k]) begin
                mlen[k] = 0;
                mpos[k] = 0;
            end else begin
                if (adv[k]) begin
                    mpos[k]++;
                    if (mpos[k] == mlen[k]) begin
                        mlen[k] = 0;
                        mpos[k] = 0;
                    end
                end
                if (acc[k]) begin
                    mfr[k]  = frame_of(k, pi_w[k]);
                    mlen[k] = wof(k) + PAR;
                    mpos[k] = 0;
                end
            end
        end
        #1;
    endtask

    task automatic step0();
        step(1'b0, 0, mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t ta [$];
        vec_t tc [$];
        int   cnt;

`ifdef PISO_STREAM_PARITY_EN
        ta.push_back(mk(0, 1, 4'b0111, 1, 0, 0, 0, 1, 0));
        ta.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0));

        tc.push_back(mk(0, 1, 4'b1100, 1, 1, 0, 0, 1, 0));
        tc.push_back(mk(0, 1, 4'b0011, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 0, 1, 1, 1, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 1, 1, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0));
`else
        ta.push_back(mk(0, 1, 4'b1010, 1, 0, 0, 0, 1, 0));
        ta.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1));
        ta.push_back(mk(0, 0, 4'b0000, 1, 0, 0, 0, 1, 0));

        tc.push_back(mk(0, 1, 4'b1100, 1, 1, 0, 0, 1, 0));
        tc.push_back(mk(0, 1, 4'b0011, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 1, 4'b0011, 1, 0, 1, 1, 1, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 0, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 0, 0, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 1, 1, 1, 1, 1));
        tc.push_back(mk(0, 0, 4'b0000, 1, 1, 0, 0, 1, 0));
`endif

        for (int k = 0; k < 3; k++) begin
            mfr[k] = '0; mlen[k] = 0; mpos[k] = 0;
            pi_w[k] = $urandom;
        end
        // Reset dominates even with load and shift requested.
        rst_w = '1; lv_w = '1; se_w = '1;
        step0();
        step0();
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy",  k, bz_w[k], 1'b0);
            chk("rst_valid", k, sv_w[k], 1'b0);
            chk("rst_last",  k, sl_w[k], 1'b0);
            chk("rst_so",    k, so_w[k], idleof(k));
        end
        rst_w = '0; lv_w = '0;
        #1;
        for (int k = 0; k < 3; k++) chk("ready_after_rst", k, lr_w[k], 1'b1);
        step0();

        foreach (ta[i]) begin
            rst_w[0] = ta[i].rst; lv_w[0] = ta[i].lv; pi_w[0] = {28'b0, ta[i].pi}; se_w[0] = ta[i].se;
            step(1'b1, 0, ta[i]);
        end
        foreach (tc[i]) begin
            rst_w[2] = tc[i].rst; lv_w[2] = tc[i].lv; pi_w[2] = {28'b0, tc[i].pi}; se_w[2] = tc[i].se;
            step(1'b1, 2, tc[i]);
        end
        lv_w = '0; se_w = '1;

        // Stall three cycles while bit 2 is on the wire.
        lv_w[1] = 1'b1; pi_w[1] = 32'hA5;
        step0();
        lv_w[1] = 1'b0; pi_w[1] = 32'h0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (sv_w[1]) cnt++;
            se_w[1] = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
            step0();
        end
        chk_int("stall_frame_len", cnt, 8 + PAR + 3);

        // Abort a frame with reset while bit 4 is on the wire.
        se_w[1] = 1'b1; lv_w[1] = 1'b1; pi_w[1] = 32'hFF;
        step0();
        lv_w[1] = 1'b0;
        for (int i = 0; i < 4; i++) step0();
        rst_w[1] = 1'b1;
        step0();
        rst_w[1] = 1'b0;
        chk("abort_valid", 1, sv_w[1], 1'b0);
        chk("abort_so",    1, so_w[1], 1'b0);
        chk("abort_ready", 1, lr_w[1], 1'b1);
        chk("abort_busy",  1, bz_w[1], 1'b0);
        lv_w[1] = 1'b1; pi_w[1] = 32'h01;
        step0();
        lv_w[1] = 1'b0;
        for (int i = 0; i < 12; i++) step0();

        // load_valid held with pi changing every cycle.
        lv_w[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            pi_w[0] = $urandom;
            step0();
        end
        lv_w[0] = 1'b0;
        for (int i = 0; i < 8; i++) step0();

        for (int n = 0; n < 2000; n++) begin
            for (int k = 0; k < 3; k++) begin
                rst_w[k] = ($urandom_range(0, 63) == 0);
                lv_w[k]  = $urandom_range(0, 1);
                se_w[k]  = ($urandom_range(0, 3) != 0);
                pi_w[k]  = $urandom;
            end
            step0();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
